// File: rtl/fpu.sv
// Single-precision floating-point adder/subtractor.
// A multi-cycle FSM that performs one operation at a time:
// IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
// Ports:
//   clk             rising-edge clock
//   arst            synchronous active-high reset (the name is historical)
//   start           level request, sampled only in IDLE
//   a_operand       IEEE-754 operand A
//   b_operand       IEEE-754 operand B
//   operation       op_sub gives A-B; every other encoding gives A+B
//   ieee_packet_out registered result, held until the next result
//   cmd_end         one-cycle pulse in DONE; the result is valid while it is high
//   busy            high in ALIGN, ADD, NORM and ROUND
// Round-to-nearest-even. Denormal inputs and results flush to signed zero.
package pa_fpu;
  typedef enum logic [1:0] {
    op_add = 2'd0,
    op_sub = 2'd1
  } e_fpu_op;
endpackage

module fpu (
  input  logic            clk,
  input  logic            arst,
  input  logic            start,
  input  logic [31:0]     a_operand,
  input  logic [31:0]     b_operand,
  input  pa_fpu::e_fpu_op operation,
  output logic [31:0]     ieee_packet_out,
  output logic            cmd_end,
  output logic            busy
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;
  state_e state_q, state_d;

  logic [31:0]        a_q, b_q;                   // operands; b already sign-flipped for subtract
  logic               spec_q, spec_d;             // special case resolved in ALIGN
  logic [31:0]        spec_res_q, spec_res_d;
  logic signed [9:0]  exp_q, exp_d;               // larger exponent, with headroom for over/underflow
  logic [26:0]        sig_big_q, sig_big_d;       // {hidden, 23-bit fraction, guard, round, sticky}
  logic [26:0]        sig_small_q, sig_small_d;
  logic               sign_big_q, sign_big_d, sign_small_q, sign_small_d;
  logic [27:0]        sum_q, sum_d;               // bit 27 is the carry-out
  logic               sign_q, sign_d;
  logic [26:0]        norm_sig_q, norm_sig_d;
  logic signed [9:0]  norm_exp_q, norm_exp_d;
  logic               zero_q;
  logic [31:0]        out_q, result_d;

  // Number of leading zeros in a 27-bit vector. Returns 27 for an all-zero input.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the edge, whatever order the statements are in.
      state_q <= state_d;
      if (state_q == S_ROUND) out_q <= result_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    busy    = 1'b0;
    cmd_end = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: begin busy = 1'b1; state_d = S_ADD;   end
      S_ADD:   begin busy = 1'b1; state_d = S_NORM;  end
      S_NORM:  begin busy = 1'b1; state_d = S_ROUND; end
      S_ROUND: begin busy = 1'b1; state_d = S_DONE;  end
      S_DONE:  begin cmd_end = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  assign ieee_packet_out = out_q;

  // ---------------- ALIGN: unpack, special cases, shift the smaller operand ----------------
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [7:0]  e_big, e_small, shamt;
  logic [23:0] m_small;
  logic [53:0] wide;

  always_comb begin
    a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
    b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
    a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
    b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
    a_zero = (a_q[30:23] == 8'h00);               // denormals count as zero
    b_zero = (b_q[30:23] == 8'h00);

    spec_d     = 1'b1;
    spec_res_d = '0;
    if (a_nan || b_nan)      spec_res_d = QNAN;
    else if (a_inf && b_inf) spec_res_d = (a_q[31] == b_q[31]) ? a_q : QNAN;
    else if (a_inf)          spec_res_d = a_q;
    else if (b_inf)          spec_res_d = b_q;
    else if (a_zero && b_zero) spec_res_d = {a_q[31] & b_q[31], 31'b0};
    else if (a_zero)         spec_res_d = b_q;
    else if (b_zero)         spec_res_d = a_q;
    else                     spec_d = 1'b0;

    swap         = b_q[30:23] > a_q[30:23];
    e_big        = swap ? b_q[30:23] : a_q[30:23];
    e_small      = swap ? a_q[30:23] : b_q[30:23];
    sign_big_d   = swap ? b_q[31] : a_q[31];
    sign_small_d = swap ? a_q[31] : b_q[31];
    sig_big_d    = {1'b1, (swap ? b_q[22:0] : a_q[22:0]), 3'b000};
    m_small      = {1'b1, (swap ? a_q[22:0] : b_q[22:0])};
    shamt        = e_big - e_small;
    exp_d        = $signed({2'b00, e_big});

    // Shift through a 27-bit tail so every bit that falls off lands in the sticky OR.
    wide = {m_small, 3'b000, 27'd0} >> shamt;
    if (shamt >= 8'd27) sig_small_d = 27'd1;
    else                sig_small_d = {wide[53:28], wide[27] | (|wide[26:0])};
  end

  // ---------------- ADD: signed-magnitude add ----------------
  always_comb begin
    if (sign_big_q == sign_small_q) begin
      sum_d  = {1'b0, sig_big_q} + {1'b0, sig_small_q};
      sign_d = sign_big_q;
    end else if (sig_big_q >= sig_small_q) begin
      sum_d  = {1'b0, sig_big_q} - {1'b0, sig_small_q};
      sign_d = sign_big_q;
    end else begin
      // Only reachable with equal exponents, where the "small" side has the larger fraction.
      sum_d  = {1'b0, sig_small_q} - {1'b0, sig_big_q};
      sign_d = sign_small_q;
    end
  end

  // ---------------- NORM ----------------
  logic [4:0] lz;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      norm_sig_d = {sum_q[27:2], |sum_q[1:0]};
      norm_exp_d = exp_q + 10'sd1;
    end else begin
      norm_sig_d = sum_q[26:0] << lz;
      norm_exp_d = exp_q - $signed({5'b0, lz});
    end
  end

  // ---------------- ROUND: nearest-even, then pack ----------------
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;

  always_comb begin
    round_up = norm_sig_q[2] & (norm_sig_q[1] | norm_sig_q[0] | norm_sig_q[3]);
    mant_r   = {1'b0, norm_sig_q[26:3]} + 25'(round_up);
    // A rounding carry leaves the fraction all-zero and bumps the exponent.
    exp_r    = norm_exp_q + $signed({9'b0, mant_r[24]});
    if (spec_q)                    result_d = spec_res_q;
    else if (zero_q)               result_d = 32'h0000_0000;
    else if (exp_r >= 10'sd255)    result_d = {sign_q, 8'hFF, 23'b0};
    else if (exp_r < 10'sd1)       result_d = {sign_q, 31'b0};
    else                           result_d = {sign_q, exp_r[7:0],
                                               (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
  end

  // ---------------- Datapath registers ----------------
  // NOTE: these registers carry no reset; each is written in its own state before
  // being read, and the FSM reset alone guarantees no stale value reaches the output.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      a_q <= a_operand;
      b_q <= (operation == pa_fpu::op_sub) ? {~b_operand[31], b_operand[30:0]} : b_operand;
    end
    if (state_q == S_ALIGN) begin
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      exp_q        <= exp_d;
      sig_big_q    <= sig_big_d;
      sig_small_q  <= sig_small_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
    end
    if (state_q == S_ADD) begin
      sum_q  <= sum_d;
      sign_q <= sign_d;
    end
    if (state_q == S_NORM) begin
      norm_sig_q <= norm_sig_d;
      norm_exp_q <= norm_exp_d;
      zero_q     <= (sum_q == '0);
    end
  end
endmodule

// File: tb/tb_fpu.sv
// Testbench for fpu: random and directed add/sub operations scored against an
// exact-arithmetic reference model, plus handshake timing and reset checks.
module tb_fpu;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst, start;
  logic [31:0] a_operand, b_operand;
  e_fpu_op     operation;
  logic [31:0] ieee_packet_out;
  logic        cmd_end, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_fifo[$];

  fpu dut (
    .clk(clk), .arst(arst), .start(start),
    .a_operand(a_operand), .b_operand(b_operand), .operation(operation),
    .ieee_packet_out(ieee_packet_out), .cmd_end(cmd_end), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact sum of the two values, then round-to-nearest-even to 24 bits.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b_in, input int op);
    logic [31:0] b;
    longint va, vb, sum, mag, q, rem, half;
    int ea, eb, elo, d, p, shift, e;
    bit s;
    b  = (op == 1) ? {~b_in[31], b_in[30:0]} : b_in;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {a[31] & b[31], 31'b0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    d = (ea > eb) ? ea - eb : eb - ea;
    // Beyond 30 binades the smaller operand is under a quarter ulp: the larger wins.
    if (d > 30) return (ea > eb) ? a : b;
    elo = (ea < eb) ? ea : eb;
    va = longint'({1'b1, a[22:0]}) << (ea - elo);
    vb = longint'({1'b1, b[22:0]}) << (eb - elo);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 32'h0;
    s   = (sum < 0);
    mag = s ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p > 23) begin
      shift = p - 23;
      q     = mag >> shift;
      rem   = mag & ((64'sd1 << shift) - 1);
      half  = 64'sd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 << 24)) begin q = q >> 1; shift++; end
      e = elo + shift;
    end else begin
      q = mag << (23 - p);
      e = elo - (23 - p);
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e < 1) return {s, 31'b0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // Monitor: every result pulse is compared with the oldest expected value.
  always @(negedge clk) begin
    if (arst === 1'b0 && cmd_end === 1'b1) begin
      if (exp_fifo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd_end: got result %h expected no pulse", ieee_packet_out);
      end else begin
        check("result", ieee_packet_out, exp_fifo.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && cmd_end === 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%b cmd_end=%b expected idle", busy, cmd_end);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op);
    wait_idle();
    a_operand = a;
    b_operand = b;
    operation = op;
    start     = 1'b1;
    exp_fifo.push_back(ref_model(a, b, int'(op)));
    @(negedge clk);
    start     = 1'b0;
    // Scramble inputs after the sampling edge; the operation must not notice.
    a_operand = $urandom;
    b_operand = $urandom;
    operation = e_fpu_op'($urandom_range(0, 3));
  endtask

  function automatic logic [31:0] rand_fp(input int e);
    int ec = e;
    if (ec < 1) ec = 1;
    if (ec > 254) ec = 254;
    return {1'($urandom_range(0, 1)), 8'(ec), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_special();
    logic [31:0] tbl[6] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h0};
    int k = $urandom_range(0, 6);
    if (k == 6) return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};   // denormal
    if (k == 5) return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
    return tbl[k];
  endfunction

  logic [31:0] dir_a[12] = '{32'h3F800000, 32'h41800000, 32'h3E800000, 32'h42168F5C,
                             32'h00000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7F800000, 32'h3F800000, 32'h41200000, 32'h80000000};
  logic [31:0] dir_b[12] = '{32'h3F8CCCCD, 32'h42000000, 32'h3F000000, 32'h00000000,
                             32'h3F800000, 32'h41200000, 32'h00000000, 32'h402DF854,
                             32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h80000000};
  logic [1:0]  dir_op[12] = '{2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [31:0] dir_req[12] = '{32'h40066666, 32'h42400000, 32'h3F400000, 32'h42168F5C,
                              32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                              32'h7FC00000, 32'h00000000, 32'h41100000, 32'h80000000};

  initial begin
    logic [31:0] ra, rb;
    int cls, wait_n;
    arst = 1'b1; start = 1'b0;
    a_operand = '0; b_operand = '0; operation = op_add;
    repeat (2) @(negedge clk);
    check("reset_out", ieee_packet_out, 32'h0);
    check("reset_cmd_end", {31'b0, cmd_end}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    arst = 1'b0;
    @(negedge clk);

    // Directed vectors; the model itself is checked against the hand-derived values.
    for (int i = 0; i < 12; i++) begin
      check($sformatf("model_vec%0d", i), ref_model(dir_a[i], dir_b[i], int'(dir_op[i])), dir_req[i]);
      issue(dir_a[i], dir_b[i], e_fpu_op'(dir_op[i]));
    end

    // Timing: start held high through the whole operation and DONE.
    wait_idle();
    a_operand = 32'h40400000; b_operand = 32'h3F800000; operation = op_add;
    start = 1'b1;
    exp_fifo.push_back(ref_model(a_operand, b_operand, 0));
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("timing_busy_c%0d", j), {30'b0, busy, cmd_end}, 32'h2);
      a_operand = $urandom;
      b_operand = $urandom;
    end
    @(negedge clk);
    check("timing_done", {30'b0, busy, cmd_end}, 32'h1);
    @(negedge clk);
    check("timing_idle_after_done", {30'b0, busy, cmd_end}, 32'h0);
    a_operand = 32'h3F800000; b_operand = 32'h3F800000; operation = op_sub;
    exp_fifo.push_back(32'h00000000);
    @(negedge clk);
    check("timing_restart", {30'b0, busy, cmd_end}, 32'h2);
    start = 1'b0;

    // Reset during NORM discards the operation.
    wait_idle();
    a_operand = 32'h41200000; b_operand = 32'h3F800000; operation = op_add;
    start = 1'b1;
    @(negedge clk);                         // ALIGN
    start = 1'b0;
    repeat (2) @(negedge clk);              // ADD, NORM
    arst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {ieee_packet_out[29:0], busy, cmd_end}, 32'h0);
    check("midreset_out_hi", {30'b0, ieee_packet_out[31:30]}, 32'h0);
    arst = 1'b0;
    repeat (8) @(negedge clk);              // monitor reports any stray pulse

    // Randomized operations across normal, near-cancel, far-shift, overflow and underflow.
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 9);
      case (cls)
        0: begin ra = rand_special(); rb = rand_fp($urandom_range(1, 254)); end
        1: begin ra = rand_fp($urandom_range(1, 254)); rb = rand_special(); end
        2: begin ra = rand_special(); rb = rand_special(); end
        3: begin ra = rand_fp($urandom_range(250, 254)); rb = rand_fp($urandom_range(250, 254)); end
        4: begin ra = rand_fp($urandom_range(1, 4)); rb = rand_fp($urandom_range(1, 4)); end
        5: begin ra = rand_fp($urandom_range(60, 200));
                 rb = {ra[31:8], 8'($urandom)} ^ {1'($urandom_range(0, 1)), 31'b0}; end
        6: begin ra = rand_fp($urandom_range(90, 160));
                 rb = rand_fp(int'(ra[30:23]) + $urandom_range(0, 70) - 35); end
        default: begin ra = rand_fp($urandom_range(100, 150));
                 rb = rand_fp(int'(ra[30:23]) + $urandom_range(0, 6) - 3); end
      endcase
      issue(ra, rb, e_fpu_op'($urandom_range(0, 3)));
    end

    wait_n = 0;
    while (exp_fifo.size() != 0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("fifo_drained", exp_fifo.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
